// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station slice.
// Tag width is derived from the default ROB depth; tag 0 means "operand present".
package rs_pkg;

  localparam int ROB_SIZE = 32;
  localparam int TAG_W    = $clog2(ROB_SIZE + 1);
  localparam int DATA_W   = 64;
  localparam int CMD_W    = 10;

  localparam int CMD_MEMWRITE  = 0;
  localparam int CMD_MEMTOREG  = 1;
  localparam int CMD_ALUOP_LSB = 2;
  localparam int CMD_REGWRITE  = 5;
  localparam int CMD_FWD       = 6;
  localparam int CMD_LSHIFT    = 7;
  localparam int CMD_SAVECOND  = 8;
  localparam int CMD_RDEN      = 9;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CMD_W-1:0]  cmd_t;

  typedef struct packed {
    logic  valid;
    tag_t  robTag;
    tag_t  tag1;
    tag_t  tag2;
    data_t val1;
    data_t val2;
    cmd_t  commands;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and issue bundle between decode, the station and its execution unit.
// master = decode/EU/CDB side, slave = the reservation station.
interface reservation_station_if #(
  parameter int ENTRIES    = 4,
  parameter int ROBsizeLog = rs_pkg::TAG_W
);
  import rs_pkg::*;

  localparam int OccW = $clog2(ENTRIES + 1);

  logic                  writeEn_i;
  logic [ROBsizeLog-1:0] robTag_i;
  logic [ROBsizeLog-1:0] tag1_i;
  logic [ROBsizeLog-1:0] tag2_i;
  logic [DATA_W-1:0]     val1_i;
  logic [DATA_W-1:0]     val2_i;
  logic [CMD_W-1:0]      commands_i;
  logic                  stall_o;
  logic                  cdbValid_i;
  logic [ROBsizeLog-1:0] cdbTag_i;
  logic [DATA_W-1:0]     cdbData_i;
  logic                  flush_i;
  logic                  issueValid_o;
  logic                  issueReady_i;
  logic [ROBsizeLog-1:0] issueROBTag_o;
  logic [DATA_W-1:0]     issueVal1_o;
  logic [DATA_W-1:0]     issueVal2_o;
  logic [CMD_W-1:0]      issueCommands_o;
  logic [OccW-1:0]       occupancy_o;

  modport master (
    output writeEn_i, robTag_i, tag1_i, tag2_i, val1_i, val2_i, commands_i,
    output cdbValid_i, cdbTag_i, cdbData_i, flush_i, issueReady_i,
    input  stall_o, issueValid_o, issueROBTag_o, issueVal1_o, issueVal2_o,
    input  issueCommands_o, occupancy_o
  );

  modport slave (
    input  writeEn_i, robTag_i, tag1_i, tag2_i, val1_i, val2_i, commands_i,
    input  cdbValid_i, cdbTag_i, cdbData_i, flush_i, issueReady_i,
    output stall_o, issueValid_o, issueROBTag_o, issueVal1_o, issueVal2_o,
    output issueCommands_o, occupancy_o
  );

endinterface

// File: rtl/rs_issue_select.sv
// One-hot issue grant over the ready entries: lowest index by default,
// oldest ready entry when RS_OLDEST_FIRST_EN is defined.
module rs_issue_select #(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0] ready,
`ifdef RS_OLDEST_FIRST_EN
  // age[i][j] set means entry j was allocated before entry i
  input  logic [ENTRIES-1:0] age [ENTRIES],
`endif
  output logic [ENTRIES-1:0] grant,
  output logic               anyReady
);

  assign anyReady = |ready;

`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = ready[i] && ((age[i] & ready) == '0);
    end
  end
`else
  assign grant = ready & (~ready + ENTRIES'(1));
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched micro-ops, wakes operands from the CDB
// and issues ready entries. RS_OLDEST_FIRST_EN switches issue to oldest-first.
module reservation_station
  import rs_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int ROBsize    = ROB_SIZE,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input logic                  clk_i,
  input logic                  reset_ni,
  reservation_station_if.slave bus
);

  localparam int OccW = $clog2(ENTRIES + 1);

  rs_entry_t             entry [ENTRIES];
  rs_entry_t             newEntry;
  logic [ENTRIES-1:0]    validVec;
  logic [ENTRIES-1:0]    readyVec;
  logic [ENTRIES-1:0]    freeVec;
  logic [ENTRIES-1:0]    freeGrant;
  logic [ENTRIES-1:0]    issueGrant;
  logic [OccW-1:0]       occupancy;
  logic [ROBsizeLog-1:0] cdbTag;
  logic                  anyReady;
  logic                  stall;
  logic                  allocate;
  logic                  issueFire;

  assign cdbTag = bus.cdbTag_i;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      validVec[i] = entry[i].valid;
      readyVec[i] = entry[i].valid && (entry[i].tag1 == '0) && (entry[i].tag2 == '0);
      occupancy   = occupancy + OccW'(entry[i].valid);
    end
  end

  assign freeVec   = ~validVec;
  assign freeGrant = freeVec & (~freeVec + ENTRIES'(1));
  assign stall     = (occupancy == OccW'(ENTRIES));
  assign allocate  = bus.writeEn_i && !stall && !bus.flush_i;
  assign issueFire = anyReady && bus.issueReady_i;

  // A dispatched operand whose producer broadcasts this very cycle is captured here.
  always_comb begin
    newEntry.valid    = 1'b1;
    newEntry.robTag   = bus.robTag_i;
    newEntry.tag1     = bus.tag1_i;
    newEntry.tag2     = bus.tag2_i;
    newEntry.val1     = bus.val1_i;
    newEntry.val2     = bus.val2_i;
    newEntry.commands = bus.commands_i;
    if (bus.cdbValid_i && (bus.tag1_i != '0) && (bus.tag1_i == cdbTag)) begin
      newEntry.tag1 = '0;
      newEntry.val1 = bus.cdbData_i;
    end
    if (bus.cdbValid_i && (bus.tag2_i != '0) && (bus.tag2_i == cdbTag)) begin
      newEntry.tag2 = '0;
      newEntry.val2 = bus.cdbData_i;
    end
  end

  // NOTE: the whole entry is reset, not just valid, so issue outputs are never X.
  // NOTE: sequential state uses <= so all entries update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) entry[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (entry[i].valid) begin
          if (bus.cdbValid_i && (entry[i].tag1 != '0) && (entry[i].tag1 == cdbTag)) begin
            entry[i].val1 <= bus.cdbData_i;
            entry[i].tag1 <= '0;
          end
          if (bus.cdbValid_i && (entry[i].tag2 != '0) && (entry[i].tag2 == cdbTag)) begin
            entry[i].val2 <= bus.cdbData_i;
            entry[i].tag2 <= '0;
          end
          if (issueFire && issueGrant[i]) entry[i].valid <= 1'b0;
        end else if (allocate && freeGrant[i]) begin
          entry[i] <= newEntry;
        end
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [ENTRIES-1:0] age [ENTRIES];

  // A new row records every surviving entry as older; its column is cleared
  // so stale bits from the slot's previous occupant cannot outrank it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int r = 0; r < ENTRIES; r++) age[r] <= '0;
    end else if (bus.flush_i) begin
      for (int r = 0; r < ENTRIES; r++) age[r] <= '0;
    end else begin
      for (int r = 0; r < ENTRIES; r++) begin
        for (int c = 0; c < ENTRIES; c++) begin
          if (allocate && freeGrant[r]) begin
            age[r][c] <= validVec[c] && !(issueFire && issueGrant[c]);
          end else if ((issueFire && issueGrant[r]) || (allocate && freeGrant[c])) begin
            age[r][c] <= 1'b0;
          end
        end
      end
    end
  end
`endif

  rs_issue_select #(.ENTRIES(ENTRIES)) u_select (
    .ready    (readyVec),
`ifdef RS_OLDEST_FIRST_EN
    .age      (age),
`endif
    .grant    (issueGrant),
    .anyReady (anyReady)
  );

  always_comb begin
    bus.issueROBTag_o   = '0;
    bus.issueVal1_o     = '0;
    bus.issueVal2_o     = '0;
    bus.issueCommands_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (issueGrant[i]) begin
        bus.issueROBTag_o   = bus.issueROBTag_o   | entry[i].robTag;
        bus.issueVal1_o     = bus.issueVal1_o     | entry[i].val1;
        bus.issueVal2_o     = bus.issueVal2_o     | entry[i].val2;
        bus.issueCommands_o = bus.issueCommands_o | entry[i].commands;
      end
    end
  end

  assign bus.stall_o      = stall;
  assign bus.issueValid_o = anyReady;
  assign bus.occupancy_o  = occupancy;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed literal cases plus random traffic against a
// slot/sequence-number model of the reservation station.
module tb_reservation_station;
  import rs_pkg::*;

  localparam int ENTRIES = 4;
  localparam int TW      = TAG_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reservation_station_if #(.ENTRIES(ENTRIES), .ROBsizeLog(TW)) rsIf ();

  reservation_station #(.ENTRIES(ENTRIES)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (rsIf)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              mValid [ENTRIES];
  logic [TW-1:0]   mRob   [ENTRIES];
  logic [TW-1:0]   mT1    [ENTRIES];
  logic [TW-1:0]   mT2    [ENTRIES];
  logic [63:0]     mV1    [ENTRIES];
  logic [63:0]     mV2    [ENTRIES];
  logic [9:0]      mCmd   [ENTRIES];
  int unsigned     mSeq   [ENTRIES];
  int unsigned     seqCnt = 0;
  int              preSel, preOcc, freeIdx;

  function automatic bit mReady(input int i);
    return mValid[i] && (mT1[i] == '0) && (mT2[i] == '0);
  endfunction

  function automatic int mOcc();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) if (mValid[i]) n++;
    return n;
  endfunction

  function automatic int mSel();
    int s = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (mReady(i)) begin
`ifdef RS_OLDEST_FIRST_EN
        if (s < 0 || mSeq[i] < mSeq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
      seqCnt = 0;
    end else begin
      preSel  = mSel();
      preOcc  = mOcc();
      freeIdx = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) if (!mValid[i]) freeIdx = i;
      if (rsIf.flush_i) begin
        for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
      end else begin
        if (rsIf.cdbValid_i) begin
          for (int i = 0; i < ENTRIES; i++) begin
            if (mValid[i] && mT1[i] != '0 && mT1[i] == rsIf.cdbTag_i) begin
              mT1[i] = '0; mV1[i] = rsIf.cdbData_i;
            end
            if (mValid[i] && mT2[i] != '0 && mT2[i] == rsIf.cdbTag_i) begin
              mT2[i] = '0; mV2[i] = rsIf.cdbData_i;
            end
          end
        end
        if (preSel >= 0 && rsIf.issueReady_i) mValid[preSel] = 1'b0;
        if (rsIf.writeEn_i && preOcc < ENTRIES) begin
          mValid[freeIdx] = 1'b1;
          mRob[freeIdx]   = rsIf.robTag_i;
          mT1[freeIdx]    = rsIf.tag1_i;
          mT2[freeIdx]    = rsIf.tag2_i;
          mV1[freeIdx]    = rsIf.val1_i;
          mV2[freeIdx]    = rsIf.val2_i;
          mCmd[freeIdx]   = rsIf.commands_i;
          if (rsIf.cdbValid_i && rsIf.tag1_i != '0 && rsIf.tag1_i == rsIf.cdbTag_i) begin
            mT1[freeIdx] = '0; mV1[freeIdx] = rsIf.cdbData_i;
          end
          if (rsIf.cdbValid_i && rsIf.tag2_i != '0 && rsIf.tag2_i == rsIf.cdbTag_i) begin
            mT2[freeIdx] = '0; mV2[freeIdx] = rsIf.cdbData_i;
          end
          mSeq[freeIdx] = seqCnt;
          seqCnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int s;
    s = mSel();
    check("issueValid", rsIf.issueValid_o, (s >= 0));
    check("issueROBTag", rsIf.issueROBTag_o, (s >= 0) ? mRob[s] : '0);
    check("issueVal1", rsIf.issueVal1_o, (s >= 0) ? mV1[s] : '0);
    check("issueVal2", rsIf.issueVal2_o, (s >= 0) ? mV2[s] : '0);
    check("issueCommands", rsIf.issueCommands_o, (s >= 0) ? mCmd[s] : '0);
    check("stall", rsIf.stall_o, (mOcc() == ENTRIES));
    check("occupancy", rsIf.occupancy_o, mOcc());
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rsIf.writeEn_i    = 1'b0;
    rsIf.robTag_i     = '0;
    rsIf.tag1_i       = '0;
    rsIf.tag2_i       = '0;
    rsIf.val1_i       = '0;
    rsIf.val2_i       = '0;
    rsIf.commands_i   = '0;
    rsIf.cdbValid_i   = 1'b0;
    rsIf.cdbTag_i     = '0;
    rsIf.cdbData_i    = '0;
    rsIf.flush_i      = 1'b0;
    rsIf.issueReady_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int rob, input int t1, input int t2,
                          input logic [63:0] v1, input logic [63:0] v2, input logic [9:0] cmd);
    rsIf.writeEn_i  = 1'b1;
    rsIf.robTag_i   = TW'(rob);
    rsIf.tag1_i     = TW'(t1);
    rsIf.tag2_i     = TW'(t2);
    rsIf.val1_i     = v1;
    rsIf.val2_i     = v2;
    rsIf.commands_i = cmd;
  endtask

  task automatic cdb(input int tag, input logic [63:0] data);
    rsIf.cdbValid_i = 1'b1;
    rsIf.cdbTag_i   = TW'(tag);
    rsIf.cdbData_i  = data;
  endtask

  task automatic accept();
    rsIf.issueReady_i = 1'b1;
    tick();
    rsIf.issueReady_i = 1'b0;
  endtask

  initial begin
    idle();
    #12 rst_n = 1'b1;
    tick();

    // reset state
    check("rst_stall", rsIf.stall_o, 0);
    check("rst_issueValid", rsIf.issueValid_o, 0);
    check("rst_occupancy", rsIf.occupancy_o, 0);
    check("rst_issueROBTag", rsIf.issueROBTag_o, 0);
    check("rst_issueVal1", rsIf.issueVal1_o, 0);

    // simple ready op
    dispatch(3, 0, 0, 64'd5, 64'd7, 10'h2A5); tick(); idle();
    check("t1_issueValid", rsIf.issueValid_o, 1);
    check("t1_robTag", rsIf.issueROBTag_o, 3);
    check("t1_val1", rsIf.issueVal1_o, 5);
    check("t1_val2", rsIf.issueVal2_o, 7);
    check("t1_cmd", rsIf.issueCommands_o, 10'h2A5);
    check("t1_occ", rsIf.occupancy_o, 1);
    accept();
    check("t1_occ_after", rsIf.occupancy_o, 0);
    check("t1_iv_after", rsIf.issueValid_o, 0);

    // wakeup via CDB
    dispatch(8, 2, 0, 64'h999, 64'd1, 10'h0); tick(); idle();
    check("t2_waiting", rsIf.issueValid_o, 0);
    cdb(2, 64'hAB); tick(); idle();
    check("t2_woken", rsIf.issueValid_o, 1);
    check("t2_val1", rsIf.issueVal1_o, 64'hAB);
    accept();

    // fill, stall, ignored write, broadcast wake, drain
    for (int k = 0; k < 4; k++) begin
      dispatch(10 + k, 0, 6, 64'(k), 64'(100 + k), 10'h0); tick(); idle();
    end
    check("t3_stall", rsIf.stall_o, 1);
    check("t3_occ", rsIf.occupancy_o, 4);
    dispatch(20, 0, 0, 64'd1, 64'd1, 10'h0); tick(); idle();
    check("t3_ignored_occ", rsIf.occupancy_o, 4);
    check("t3_ignored_iv", rsIf.issueValid_o, 0);
    cdb(6, 64'h66); tick(); idle();
    rsIf.issueReady_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_drain_iv", rsIf.issueValid_o, 1);
      check("t3_drain_rob", rsIf.issueROBTag_o, 10 + k);
      check("t3_drain_val2", rsIf.issueVal2_o, 64'h66);
      tick();
    end
    rsIf.issueReady_i = 1'b0;
    check("t3_occ_empty", rsIf.occupancy_o, 0);
    check("t3_unstall", rsIf.stall_o, 0);

    // dispatch bypass
    dispatch(21, 4, 0, 64'h55, 64'd2, 10'h0); cdb(4, 64'h11); tick(); idle();
    check("t4_iv", rsIf.issueValid_o, 1);
    check("t4_val1", rsIf.issueVal1_o, 64'h11);
    check("t4_rob", rsIf.issueROBTag_o, 21);
    accept();

    // flush beats a same-cycle write
    for (int k = 0; k < 3; k++) begin
      dispatch(22 + k, 7, 7, 64'd0, 64'd0, 10'h0); tick(); idle();
    end
    check("t5_occ3", rsIf.occupancy_o, 3);
    dispatch(30, 0, 0, 64'd9, 64'd9, 10'h0); rsIf.flush_i = 1'b1; tick(); idle();
    check("t5_occ", rsIf.occupancy_o, 0);
    check("t5_iv", rsIf.issueValid_o, 0);

    // age ordering: A waiting in slot 0, B ready in slot 1, C reuses slot 1
    dispatch(1, 9, 0, 64'd0, 64'd0, 10'h0); tick();
    dispatch(2, 0, 0, 64'd0, 64'd0, 10'h0); tick(); idle();
    check("t6_B", rsIf.issueROBTag_o, 2);
    accept();
    dispatch(3, 0, 0, 64'd0, 64'd0, 10'h0); tick(); idle();
    check("t6_C_only", rsIf.issueROBTag_o, 3);
    cdb(9, 64'h99); tick(); idle();
    check("t6_A_first", rsIf.issueROBTag_o, 1);
    accept();
    check("t6_C_next", rsIf.issueROBTag_o, 3);
    accept();
    check("t6_empty", rsIf.occupancy_o, 0);

    // older entry in a higher slot than a younger ready entry
    dispatch(4, 0, 0, 64'd0, 64'd0, 10'h0); tick();
    dispatch(5, 0, 0, 64'd0, 64'd0, 10'h0); tick(); idle();
    accept();
    dispatch(6, 0, 0, 64'd0, 64'd0, 10'h0); tick(); idle();
`ifdef RS_OLDEST_FIRST_EN
    check("t6b_oldest", rsIf.issueROBTag_o, 5);
`else
    check("t6b_lowest", rsIf.issueROBTag_o, 6);
`endif
    accept();
    accept();

    // asynchronous reset mid-operation
    dispatch(11, 0, 0, 64'd1, 64'd1, 10'h0); tick();
    dispatch(12, 3, 0, 64'd1, 64'd1, 10'h0); tick(); idle();
    check("t7_occ2", rsIf.occupancy_o, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_occ", rsIf.occupancy_o, 0);
    check("t7_rst_iv", rsIf.issueValid_o, 0);
    check("t7_rst_rob", rsIf.issueROBTag_o, 0);
    #3 rst_n = 1'b1;
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rsIf.writeEn_i    = ($urandom_range(0, 99) < 60);
      rsIf.robTag_i     = TW'($urandom_range(1, 31));
      rsIf.tag1_i       = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 5));
      rsIf.tag2_i       = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 5));
      rsIf.val1_i       = {$urandom(), $urandom()};
      rsIf.val2_i       = {$urandom(), $urandom()};
      rsIf.commands_i   = 10'($urandom());
      rsIf.cdbValid_i   = ($urandom_range(0, 1) == 1);
      rsIf.cdbTag_i     = TW'($urandom_range(1, 5));
      rsIf.cdbData_i    = {$urandom(), $urandom()};
      rsIf.issueReady_i = ($urandom_range(0, 99) < 60);
      rsIf.flush_i      = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
